// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared constants and types for the binary-to-BCD converter.
//   state_t        : FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//   BCD_DIGIT_W    : bits per BCD digit
//   ADD3_THRESHOLD : digit value at or above which +3 is applied
//   ADD3_VALUE     : correction added to a digit before each shift
//   ERROR_DIGIT    : digit code shown on every digit when the result overflows
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
  localparam logic [3:0] ADD3_VALUE     = 4'd3;
  localparam logic [3:0] ERROR_DIGIT    = 4'hF;

endpackage : bcd_pkg

// File: rtl/bcd_add3_digit.sv
// ---------------------------------------------------------------------------
// bcd_add3_digit
// Combinational double-dabble correction for a single BCD digit: adds 3 when
// the digit is 5 or more, so that the following left shift carries correctly
// into the next decade. No carry leaves the digit.
// Ports:
//   digit_i : 4-bit scratch digit before correction
//   digit_o : 4-bit corrected digit
// ---------------------------------------------------------------------------
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADD3_THRESHOLD) ? (digit_i + ADD3_VALUE) : digit_i;

endmodule : bcd_add3_digit

// File: rtl/binary_to_bcd_converter.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_converter
// Sequential shift-and-add-3 (double-dabble) converter, one input bit per
// clock. A conversion is accepted with start while ready is high, runs for
// BIN_WIDTH cycles in SHIFT, then spends one cycle in DONE where the new
// result is presented. bcd/overflow/blank are registered and only change on
// entry to DONE, so the downstream 7-segment decoders never see partial data.
//
// Parameters:
//   BIN_WIDTH : width of the binary input (1..32)
//   DIGITS    : number of BCD output digits (1..8)
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset; discards any conversion
//   start    : conversion request, sampled only while ready=1
//   binary   : value to convert, captured on the accept edge
//   ready    : converter can accept start this cycle (IDLE or DONE)
//   busy     : conversion in progress (SHIFT)
//   done     : one-cycle pulse, new result valid from this cycle
//   bcd      : packed BCD result, digit 0 (units) in bits [3:0];
//              all digits 4'hF when the value did not fit
//   overflow : last result exceeded 10^DIGITS-1
//   blank    : leading-zero blank flags
// Build option:
//   BCD_LEADING_ZERO_BLANK_EN : when defined, blank[i] (i>=1) is set when
//   digit i and every higher digit are zero; blank[0] is always 0 and all
//   flags are 0 on overflow. When undefined, blank is tied to zero.
// ---------------------------------------------------------------------------
module binary_to_bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_WIDTH-1:0]          binary,
  output logic                          ready,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow,
  output logic [DIGITS-1:0]             blank
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [SCR_W-1:0]     scr_q, scr_d;
  logic [SCR_W-1:0]     scr_corr;
  logic                 ovf_scr_q, ovf_scr_d;
  logic [SCR_W-1:0]     bcd_q, bcd_d;
  logic                 overflow_q;
  logic                 load_out;

  // Per-digit add-3 correction applied to the scratch register before shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      bcd_add3_digit u_add3 (
        .digit_i (scr_q   [gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_o (scr_corr[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scr_d     = scr_q;
    ovf_scr_d = ovf_scr_q;
    load_out  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          shift_d   = binary;
          scr_d     = '0;
          ovf_scr_d = 1'b0;
          cnt_d     = CNT_W'(BIN_WIDTH - 1);
          state_d   = ST_SHIFT;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        // {scratch, shift} << 1 after correction; the bit pushed out of the
        // top digit means the value no longer fits in DIGITS decades.
        scr_d     = {scr_corr[SCR_W-2:0], shift_q[BIN_WIDTH-1]};
        shift_d   = shift_q << 1;
        ovf_scr_d = ovf_scr_q | scr_corr[SCR_W-1];
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          load_out = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result as it will be published on DONE entry (uses the final shift).
  assign bcd_d = ovf_scr_d ? {DIGITS{ERROR_DIGIT}} : scr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      scr_q      <= '0;
      ovf_scr_q  <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scr_q     <= scr_d;
      ovf_scr_q <= ovf_scr_d;
      if (load_out) begin
        bcd_q      <= bcd_d;
        overflow_q <= ovf_scr_d;
      end
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              zero_above;

  // Walk from the top digit down; a digit is blanked only while every digit
  // above it (and itself) is zero. The units digit is never blanked.
  always_comb begin
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (scr_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_d[i] = zero_above & ~ovf_scr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= '0;
    end else if (load_out) begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

  assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_DONE);
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule : binary_to_bcd_converter

// File: tb/tb_binary_to_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_binary_to_bcd_converter
// Directed, table-driven bench for binary_to_bcd_converter at the default
// BIN_WIDTH=14, DIGITS=4, plus hand-written back-to-back, ignored-start and
// mid-conversion reset sequences. Expected blank flags follow
// BCD_LEADING_ZERO_BLANK_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_binary_to_bcd_converter;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] binary;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;
  logic [3:0]  blank;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  binary_to_bcd_converter #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .binary   (binary),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow),
    .blank    (blank)
  );

  typedef struct {
    logic [13:0] bin;
    logic [15:0] exp_bcd;
    logic        exp_ovf;
    logic [3:0]  exp_blank;   // value when blanking is enabled
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] blank_exp(input logic [3:0] b);
    return BLANK_EN ? b : 4'b0000;
  endfunction

  // Drive an accepted start; returns at the negedge of SHIFT cycle 1.
  task automatic accept(input logic [13:0] v, input bit now);
    if (!now) @(negedge clk);
    start  = 1'b1;
    binary = v;
    @(negedge clk);
    start  = 1'b0;
    binary = 14'($urandom);
  endtask

  // Follow SHIFT until done; checks busy/ready/held outputs each cycle and the
  // latency (done seen at the 15th negedge after the accept edge).
  task automatic wait_done(input string tag, input logic [15:0] hold, input bit noise);
    int k = 1;
    while (done !== 1'b1 && k < 40) begin
      chk({tag, "_busy"},  32'(busy),  32'd1);
      chk({tag, "_ready"}, 32'(ready), 32'd0);
      chk({tag, "_hold"},  32'(bcd),   32'(hold));
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        binary = 14'($urandom);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(k), 32'd15);
    chk({tag, "_ready_done"}, 32'(ready), 32'd1);
  endtask

  task automatic chk_result(input string tag, input logic [13:0] v, input logic [15:0] eb,
                            input logic eo, input logic [3:0] ebl);
    $display("conv %s bin=%0d bcd=%h ovf=%0d blank=%b", tag, v, bcd, overflow, blank);
    chk({tag, "_bcd"},   32'(bcd),      32'(eb));
    chk({tag, "_ovf"},   32'(overflow), 32'(eo));
    chk({tag, "_blank"}, 32'(blank),    32'(blank_exp(ebl)));
  endtask

  initial begin
    int   done_cnt;
    logic [15:0] prev;

    vecs[0] = '{14'd0,     16'h0000, 1'b0, 4'b1110};
    vecs[1] = '{14'd1234,  16'h1234, 1'b0, 4'b0000};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0, 4'b0000};
    vecs[3] = '{14'd10000, 16'hFFFF, 1'b1, 4'b0000};
    vecs[4] = '{14'd16383, 16'hFFFF, 1'b1, 4'b0000};
    vecs[5] = '{14'd42,    16'h0042, 1'b0, 4'b1100};
    vecs[6] = '{14'd7,     16'h0007, 1'b0, 4'b1110};
    vecs[7] = '{14'd100,   16'h0100, 1'b0, 4'b1000};

    rst    = 1'b1;
    start  = 1'b0;
    binary = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready),    32'd1);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_bcd",   32'(bcd),      32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_blank", 32'(blank),    32'd0);
    rst = 1'b0;

    // Table-driven conversions.
    prev = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      accept(vecs[i].bin, 1'b0);
      wait_done($sformatf("vec%0d", i), prev, 1'b0);
      chk_result($sformatf("vec%0d", i), vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_ovf,
                 vecs[i].exp_blank);
      prev = vecs[i].exp_bcd;
      @(negedge clk);
      chk($sformatf("vec%0d_single_done", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d_idle_ready", i), 32'(ready), 32'd1);
    end

    // Back-to-back: start 42 during the done cycle of 1234.
    accept(14'd1234, 1'b0);
    wait_done("b2b_a", prev, 1'b0);
    chk_result("b2b_a", 14'd1234, 16'h1234, 1'b0, 4'b0000);
    accept(14'd42, 1'b1);
    wait_done("b2b_b", 16'h1234, 1'b0);
    chk_result("b2b_b", 14'd42, 16'h0042, 1'b0, 4'b1100);
    @(negedge clk);
    chk("b2b_single_done", 32'(done), 32'd0);

    // Start pulses and binary toggling during SHIFT are ignored.
    accept(14'd3141, 1'b0);
    wait_done("noise", 16'h0042, 1'b1);
    chk_result("noise", 14'd3141, 16'h3141, 1'b0, 4'b0000);
    @(negedge clk);
    chk("noise_single_done", 32'(done), 32'd0);
    chk("noise_idle", 32'(busy), 32'd0);

    // Reset in SHIFT cycle 7 of 5678 after a 1234 result.
    accept(14'd1234, 1'b0);
    wait_done("pre_rst", 16'h3141, 1'b0);
    chk_result("pre_rst", 14'd1234, 16'h1234, 1'b0, 4'b0000);
    accept(14'd5678, 1'b0);
    repeat (6) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_hold", 32'(bcd),  32'h1234);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_bcd",   32'(bcd),      32'd0);
    chk("mid_rst_ovf",   32'(overflow), 32'd0);
    chk("mid_rst_blank", 32'(blank),    32'd0);
    chk("mid_rst_ready", 32'(ready),    32'd1);
    chk("mid_rst_busy",  32'(busy),     32'd0);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    $display("conv mid_rst bin=5678 discarded bcd=%h", bcd);
    accept(14'd77, 1'b0);
    wait_done("post_rst", 16'h0000, 1'b0);
    chk_result("post_rst", 14'd77, 16'h0077, 1'b0, 4'b1100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_binary_to_bcd_converter
